// File: rtl/avalon_led_pio_ext.sv
// Avalon-MM LED output PIO: DATA with atomic set/clear/toggle aliases, per-bit blink
// driven by a programmable prescaler, and a global 8-bit PWM brightness gate.
module avalon_led_pio_ext #(
    parameter int                WIDTH       = 18,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
    parameter int                PRESCALE_W  = 24
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [WIDTH-1:0]  out_port
);

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_SET    = 3'd1;
    localparam logic [2:0] A_CLR    = 3'd2;
    localparam logic [2:0] A_TOG    = 3'd3;
    localparam logic [2:0] A_BLINK  = 3'd4;
    localparam logic [2:0] A_PERIOD = 3'd5;
    localparam logic [2:0] A_DUTY   = 3'd6;
    localparam logic [2:0] A_STATUS = 3'd7;

    logic [WIDTH-1:0]      data_q,    data_d;
    logic [WIDTH-1:0]      blink_q,   blink_d;
    logic [PRESCALE_W-1:0] period_q,  period_d;
    logic [7:0]            duty_q,    duty_d;
    logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic                  phase_q,   phase_d;
    logic [7:0]            pwm_cnt_q, pwm_cnt_d;
    logic [WIDTH-1:0]      out_q,     out_d;

    logic                  wr;
    logic [WIDTH-1:0]      wd;
    logic [PRESCALE_W-1:0] wd_period;
    logic                  unused_wd;

    // Full-scale duty bypasses the compare so 8'hFF is solidly on.
    function automatic logic pwm_on_f(input logic [7:0] cnt, input logic [7:0] duty);
        pwm_on_f = (duty == 8'hFF) ? 1'b1 : (cnt < duty);
    endfunction

    assign wr        = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign wd_period = writedata[PRESCALE_W-1:0];
    assign unused_wd = ^writedata;

    always_comb begin
        data_d   = data_q;
        blink_d  = blink_q;
        period_d = period_q;
        duty_d   = duty_q;
        if (wr) begin
            case (address)
                A_DATA:   data_d   = wd;
                A_SET:    data_d   = data_q | wd;
                A_CLR:    data_d   = data_q & ~wd;
                A_TOG:    data_d   = data_q ^ wd;
                A_BLINK:  blink_d  = wd;
                A_PERIOD: period_d = wd_period;
                A_DUTY:   duty_d   = writedata[7:0];
                default:  ;
            endcase
        end
    end

    // A PERIOD write restarts the blink in its on phase, overriding terminal count.
    always_comb begin
        pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
        phase_d   = phase_q;
        if ((wr && address == A_PERIOD) || period_q == '0) begin
            pre_cnt_d = '0;
            phase_d   = 1'b1;
        end else if (pre_cnt_q == period_q) begin
            pre_cnt_d = '0;
            phase_d   = ~phase_q;
        end
    end

    assign pwm_cnt_d = pwm_cnt_q + 8'd1;
    assign out_d     = (data_q & (~blink_q | {WIDTH{phase_q}}))
                       & {WIDTH{pwm_on_f(pwm_cnt_q, duty_q)}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q    <= RESET_VALUE;
            blink_q   <= '0;
            period_q  <= '0;
            duty_q    <= 8'hFF;
            pre_cnt_q <= '0;
            phase_q   <= 1'b1;
            pwm_cnt_q <= 8'd0;
            out_q     <= RESET_VALUE;
        end else begin
            data_q    <= data_d;
            blink_q   <= blink_d;
            period_q  <= period_d;
            duty_q    <= duty_d;
            pre_cnt_q <= pre_cnt_d;
            phase_q   <= phase_d;
            pwm_cnt_q <= pwm_cnt_d;
            out_q     <= out_d;
        end
    end

    assign out_port = out_q;

    always_comb begin
        readdata = '0;
        case (address)
            A_DATA:   readdata[WIDTH-1:0]      = data_q;
            A_BLINK:  readdata[WIDTH-1:0]      = blink_q;
            A_PERIOD: readdata[PRESCALE_W-1:0] = period_q;
            A_DUTY:   readdata[7:0]            = duty_q;
            A_STATUS: begin
                readdata[0]    = phase_q;
                readdata[15:8] = pwm_cnt_q;
            end
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_avalon_led_pio_ext.sv
// Directed bench for avalon_led_pio_ext: register map, atomic updates, blink timing,
// PWM duty and asynchronous reset, each checked with an immediate assertion.
module tb_avalon_led_pio_ext;

    localparam int          WIDTH = 18;
    localparam logic [17:0] RV    = 18'h00A5;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [2:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] out_port;

    int nvec = 0;
    int nerr = 0;

    avalon_led_pio_ext #(.WIDTH(WIDTH), .RESET_VALUE(RV), .PRESCALE_W(24)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one write so it is sampled on the next posedge; returns 1 time unit after it.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        address = a;
        #1;
        v = readdata;
        address = 3'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] v2;
        int          cnt;

        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;

        // Reset values
        #12;
        chk("rst_out_during", 32'(out_port), 32'h00A5);
        rd(3'd6, v); chk("rst_duty", v, 32'h0000_00FF);
        rd(3'd7, v); chk("rst_status", v, 32'h0000_0001);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        chk("rst_out_after", 32'(out_port), 32'h00A5);
        rd(3'd0, v); chk("rst_data", v, 32'h00A5);
        rd(3'd7, v); chk("rst_phase", {31'd0, v[0]}, 32'd1);

        // Atomic register updates, 1 clk to pin
        wr(3'd0, 32'h0003_FFFF); step(); chk("out_data", 32'(out_port), 32'h3FFFF);
        wr(3'd1, 32'h0000_0000); step(); chk("out_set",  32'(out_port), 32'h3FFFF);
        wr(3'd2, 32'h0000_000F); step(); chk("out_clr",  32'(out_port), 32'h3FFF0);
        wr(3'd3, 32'h0003_0000); step(); chk("out_tog",  32'(out_port), 32'h0FFF0);
        rd(3'd0, v); chk("rd_data", v, 32'h0FFF0);
        rd(3'd1, v); chk("rd_set",  v, 32'h0);
        rd(3'd2, v); chk("rd_clr",  v, 32'h0);
        rd(3'd3, v); chk("rd_tog",  v, 32'h0);
        wr(3'd1, 32'hFFFC_0000); step(); chk("set_upper_ignored", 32'(out_port), 32'h0FFF0);
        wr(3'd0, 32'h0000_0000); step(); chk("out_zero", 32'(out_port), 32'h0);

        // Blink: PERIOD=4 gives a 5-clk half-period
        wr(3'd0, 32'h3);
        wr(3'd4, 32'h1);
        rd(3'd4, v); chk("rd_blink", v, 32'h1);
        wr(3'd5, 32'd4);
        rd(3'd5, v); chk("rd_period", v, 32'd4);
        for (int k = 1; k <= 15; k++) begin
            step();
            chk($sformatf("blink_k%0d", k), 32'(out_port[1:0]),
                (((k - 1) / 5) % 2 == 0) ? 32'h3 : 32'h2);
        end

        // PERIOD write landing on the terminal-count edge
        wr(3'd5, 32'd4);
        repeat (4) @(posedge clk);
        wr(3'd5, 32'd4);
        rd(3'd7, v); chk("tc_write_phase", {31'd0, v[0]}, 32'd1);
        for (int k = 1; k <= 6; k++) begin
            step();
            chk($sformatf("tc_restart_k%0d", k), 32'(out_port[0]), (k < 6) ? 32'd1 : 32'd0);
        end

        // PWM counter advances by one per clk
        rd(3'd7, v); step(); rd(3'd7, v2);
        chk("pwm_cnt_inc", 32'(v2[15:8]), 32'(8'(v[15:8] + 8'd1)));

        // PWM duty
        wr(3'd5, 32'd0);
        wr(3'd4, 32'd0);
        wr(3'd0, 32'h1);
        wr(3'd6, 32'd64);
        rd(3'd6, v); chk("rd_duty", v, 32'd64);
        repeat (3) step();
        cnt = 0;
        for (int k = 0; k < 256; k++) begin step(); if (out_port[0]) cnt++; end
        chk("pwm_duty64", 32'(cnt), 32'd64);
        wr(3'd6, 32'd0);
        repeat (3) step();
        cnt = 0;
        for (int k = 0; k < 256; k++) begin step(); if (out_port[0]) cnt++; end
        chk("pwm_duty0", 32'(cnt), 32'd0);
        wr(3'd6, 32'd255);
        repeat (3) step();
        cnt = 0;
        for (int k = 0; k < 256; k++) begin step(); if (out_port[0]) cnt++; end
        chk("pwm_duty255", 32'(cnt), 32'd256);

        // Asynchronous reset mid-blink
        wr(3'd6, 32'd10);
        wr(3'd0, 32'h3);
        wr(3'd4, 32'h1);
        wr(3'd5, 32'd4);
        repeat (7) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_rst_out", 32'(out_port), 32'h00A5);
        rd(3'd4, v); chk("async_rst_blink",  v, 32'h0);
        rd(3'd5, v); chk("async_rst_period", v, 32'h0);
        rd(3'd6, v); chk("async_rst_duty",   v, 32'hFF);
        rd(3'd0, v); chk("async_rst_data",   v, 32'h00A5);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        chk("post_rst_out", 32'(out_port), 32'h00A5);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
